// File: rtl/binary_mul_acc_3_uni.sv
// rtl/binary_mul_acc_3_uni.sv - frame accumulator for a pipelined multiplier's products
module binary_mul_acc_3_uni #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int P_W     = 6,
  parameter int SUM_W   = P_W + $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [P_W-1:0]   P,
  input  logic             start,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             out_valid,
  output logic             busy,
  output logic             drop
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [LATENCY-1:0] vld_sr;
  logic             pv;
  logic             p_ok;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] p_ext;
  logic [SUM_W-1:0] acc_next;

  // The shift line mirrors the multiplier pipeline, so its last stage marks
  // the cycle in which P carries the product of a presented operand pair.
  assign pv       = vld_sr[LATENCY-1];
  assign p_ok     = pv & en;
  assign p_ext    = {{(SUM_W-P_W){1'b0}}, P};
  assign acc_next = acc + p_ext;

  generate
    if (LATENCY == 1) begin : g_sr_single
      // Single-stage valid line: advances with the multiplier enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
        end else if (en) begin
          vld_sr[0] <= in_valid;
        end
      end
    end else begin : g_sr_multi
      // Multi-stage valid line: advances with the multiplier enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
        end else if (en) begin
          vld_sr <= {vld_sr[LATENCY-2:0], in_valid};
        end
      end
    end
  endgenerate

  // Frame control: accumulate DEPTH aligned products, present the sum, and
  // flag any aligned product that arrives while no frame is collecting.
  // A product arriving together with a frame-opening start is still a
  // discard, so the drop set is written last and overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      drop      <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACC;
            busy  <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
            drop  <= 1'b0;
          end
          if (p_ok) begin
            drop <= 1'b1;
          end
        end

        ACC: begin
          if (p_ok) begin
            acc <= acc_next;
            if (cnt == CNT_LAST) begin
              sum       <= acc_next;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state <= ACC;
              busy  <= 1'b1;
              acc   <= '0;
              cnt   <= '0;
              drop  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          if (p_ok) begin
            drop <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_mul_acc_3_uni.sv
// tb/tb_binary_mul_acc_3_uni.sv - scoreboard bench for binary_mul_acc_3_uni
module tb_binary_mul_acc_3_uni;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int P_W     = 6;
  localparam int SUM_W   = P_W + $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b1;
  logic             in_valid = 1'b0;
  logic [P_W-1:0]   P = '0;
  logic             start = 1'b0;
  logic             out_ready = 1'b1;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
  logic             busy;
  logic             drop;

  logic [P_W-1:0]   op_p = '0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int fp[DEPTH];

  // upstream multiplier model state
  logic           up_v[LATENCY];
  logic [P_W-1:0] up_p[LATENCY];
  logic           s_en;
  logic           s_v;
  logic [P_W-1:0] s_p;

  binary_mul_acc_3_uni #(
    .LATENCY(LATENCY),
    .DEPTH(DEPTH),
    .P_W(P_W),
    .SUM_W(SUM_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .in_valid(in_valid),
    .P(P),
    .start(start),
    .out_ready(out_ready),
    .sum(sum),
    .out_valid(out_valid),
    .busy(busy),
    .drop(drop)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < LATENCY; i++) begin
      up_v[i] = 1'b0;
      up_p[i] = '0;
    end
  end

  // Upstream multiplier: product appears LATENCY enabled cycles after its
  // operands; junk is driven on P when no product is due.
  always @(posedge clk) begin
    s_en = en;
    s_v  = in_valid;
    s_p  = op_p;
    #1;
    if (s_en) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        up_v[i] = up_v[i-1];
        up_p[i] = up_p[i-1];
      end
      up_v[0] = s_v;
      up_p[0] = s_p;
    end
    P = up_v[LATENCY-1] ? up_p[LATENCY-1] : P_W'($urandom);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted sum is compared with the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got sum=%0d expected no output", sum);
      end else begin
        check("frame_sum", sum, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_frame(input bit do_start, input int gap_max);
    bit bad;
    int total;
    int g;
    bad = 1'b0;
    total = 0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      op_p = P_W'(fp[i]);
      total += fp[i];
      tick();
      if (!busy) bad = 1'b1;
      in_valid = 1'b0;
      if (i != DEPTH - 1) begin
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
          tick();
          if (!busy) bad = 1'b1;
        end
      end
    end
    exp_q.push_back(total);
    check("busy_in_frame", bad, 0);
  endtask

  task automatic wait_out(output int n);
    bit bad;
    bad = 1'b0;
    n = 0;
    while (!out_valid && n < 64) begin
      if (!busy) bad = 1'b1;
      tick();
      n++;
    end
    check("out_valid_seen", out_valid, 1);
    check("busy_while_acc", bad, 0);
    check("busy_in_done", busy, 0);
  endtask

  task automatic stray_in_done();
    bit stable;
    logic [SUM_W-1:0] s0;
    s0 = sum;
    stable = 1'b1;
    in_valid = 1'b1;
    op_p = P_W'(5);
    tick();
    in_valid = 1'b0;
    if (!out_valid || sum != s0) stable = 1'b0;
    repeat (LATENCY) begin
      tick();
      if (!out_valid || sum != s0) stable = 1'b0;
    end
    check("done_hold_stable", stable, 1);
    check("drop_in_done", drop, 1);
  endtask

  initial begin
    int n;
    int tot;
    bit quiet;

    #2 rst_n = 1'b0;
    #1;
    check("reset_sum", sum, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_drop", drop, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // back-to-back P=49, latency to out_valid
    for (int i = 0; i < DEPTH; i++) fp[i] = 49;
    issue_frame(1'b1, 0);
    wait_out(n);
    check("latency_edges", n + 1, LATENCY + 1);
    check("sum_49x8", sum, 392);
    check("drop_clean", drop, 0);
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);

    // squares with gaps
    for (int i = 0; i < DEPTH; i++) fp[i] = i * i;
    issue_frame(1'b1, 2);
    wait_out(n);
    check("sum_squares", sum, 140);
    tick();

    // enable pause with products in flight
    for (int i = 0; i < DEPTH; i++) fp[i] = int'($urandom_range(0, 63));
    issue_frame(1'b1, 0);
    en = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      tick();
      if (out_valid) quiet = 1'b0;
    end
    en = 1'b1;
    check("no_out_while_frozen", quiet, 1);
    wait_out(n);
    tot = n + 3;
    check("latency_with_pause", tot, LATENCY + 3);
    tick();

    // held DONE with stray product
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) fp[i] = int'($urandom_range(0, 63));
    issue_frame(1'b1, 1);
    wait_out(n);
    stray_in_done();
    out_ready = 1'b1;
    tick();
    check("back_to_idle_busy", busy, 0);
    check("back_to_idle_valid", out_valid, 0);
    check("drop_sticky", drop, 1);

    // handshake and start in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) fp[i] = int'($urandom_range(0, 63));
    issue_frame(1'b1, 0);
    wait_out(n);
    stray_in_done();
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_drop_cleared", drop, 0);
    for (int i = 0; i < DEPTH; i++) fp[i] = 1;
    issue_frame(1'b0, 0);
    wait_out(n);
    check("sum_ones", sum, 8);
    check("drop_after_restart", drop, 0);
    tick();

    // reset mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op_p = P_W'(7);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_sum", sum, 0);
    check("midreset_busy", busy, 0);
    check("midreset_valid", out_valid, 0);
    check("midreset_drop", drop, 0);
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (LATENCY + 2) begin
      tick();
      if (drop || busy || out_valid) quiet = 1'b0;
    end
    check("inflight_discarded", quiet, 1);
    for (int i = 0; i < DEPTH; i++) fp[i] = 3;
    issue_frame(1'b1, 0);
    wait_out(n);
    check("sum_threes", sum, 24);
    tick();

    // randomized frames with random consumer stalls
    for (int f = 0; f < 4; f++) begin
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) fp[i] = int'($urandom_range(0, 63));
      issue_frame(1'b1, 3);
      wait_out(n);
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
    end

    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
